// File: rtl/key_led_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_led_ctrl : N-channel key sync/debounce with press/release pulses and |
// |                follow/toggle LED drive.                      Rev 1.0     |
// +--------------------------------------------------------------------------+
module key_led_ctrl #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] key,
  input  logic [N_CH-1:0] mode,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] key_press,
  output logic [N_CH-1:0] key_release
);

  localparam logic             c_PIN_RELEASED = KEY_ACTIVE_LOW;
  localparam logic [CNT_W-1:0] c_CNT_MAX      = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             s1_q, s2_q, stable_q, led_q, press_q, release_q;
    logic [CNT_W-1:0] cnt_q;
    logic             s1_d, s2_d, stable_d, led_d, press_d, release_d;
    logic [CNT_W-1:0] cnt_d;
    logic             pressed_lvl, accept;

    always_comb begin
      s1_d        = key[i];
      s2_d        = s1_q;
      // XOR with the released pin level yields 1 for pressed in either polarity
      pressed_lvl = s2_q ^ c_PIN_RELEASED;
      accept      = 1'b0;
      stable_d    = stable_q;
      cnt_d       = cnt_q;
      if (pressed_lvl == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == c_CNT_MAX) begin
        accept   = 1'b1;
        stable_d = pressed_lvl;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      press_d   = accept & stable_d;
      release_d = accept & ~stable_d;
      if (mode[i]) begin
        led_d = press_d ? ~led_q : led_q;
      end else begin
        led_d = stable_d;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q      <= c_PIN_RELEASED;
        s2_q      <= c_PIN_RELEASED;
        stable_q  <= 1'b0;
        cnt_q     <= '0;
        led_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1_q      <= s1_d;
        s2_q      <= s2_d;
        stable_q  <= stable_d;
        cnt_q     <= cnt_d;
        led_q     <= led_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign led[i]         = led_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_led_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_key_led_ctrl : scoreboard bench for key_led_ctrl (4 ch, 8-cycle debounce)|
// |                                                              Rev 1.0     |
// +--------------------------------------------------------------------------+
module tb_key_led_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'hF;
  logic [3:0] mode = 4'h0;
  logic [3:0] led, key_press, key_release;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] led;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  key_led_ctrl #(
    .N_CH(4),
    .DEBOUNCE_CYCLES(8),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .mode(mode),
    .led(led),
    .key_press(key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Capture happens at the next edge (cyc+1); accept is 9 edges after capture.
  task automatic drive_key(input logic [3:0] k, input logic [3:0] p,
                           input logic [3:0] r, input logic [3:0] l);
    key = k;
    sb.push_back('{cyc + 10, p, r, l});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick(1);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
    tick(3);
  endtask

  always @(negedge clk) begin
    if (!rst && (key_press != 4'h0 || key_release != 4'h0)) begin
      check("press_release_overlap", key_press & key_release, 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {key_press, key_release}, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("key_press", key_press, e.press);
        check("key_release", key_release, e.rel);
        check("led_at_pulse", led, e.led);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // reset with all keys released
    tick(3);
    check("reset_led", led, 0);
    check("reset_press", key_press, 0);
    check("reset_release", key_release, 0);
    rst = 1'b0;
    tick(2);
    check("idle_led", led, 0);

    // clean press/release on ch0, follow mode
    drive_key(4'b1110, 4'b0001, 4'b0000, 4'b0001);
    drain();
    check("ch0_follow_held", led, 4'b0001);
    drive_key(4'b1111, 4'b0000, 4'b0001, 4'b0000);
    drain();

    // bounce on ch1: 5 low, 2 high, then steady low
    key = 4'b1101;
    tick(5);
    key = 4'b1111;
    tick(2);
    check("bounce_no_led", led, 0);
    drive_key(4'b1101, 4'b0010, 4'b0000, 4'b0010);
    drain();
    drive_key(4'b1111, 4'b0000, 4'b0010, 4'b0000);
    drain();

    // toggle mode on ch2: two press/release sequences
    mode = 4'b0100;
    tick(1);
    drive_key(4'b1011, 4'b0100, 4'b0000, 4'b0100);
    drain();
    drive_key(4'b1111, 4'b0000, 4'b0100, 4'b0100);
    drain();
    check("toggle_hold_after_release", led, 4'b0100);
    drive_key(4'b1011, 4'b0100, 4'b0000, 4'b0000);
    drain();
    drive_key(4'b1111, 4'b0000, 4'b0100, 4'b0000);
    drain();
    mode = 4'b0000;
    tick(2);
    check("toggle_back_follow", led, 0);

    // simultaneous press on ch0 and ch3, then mode switching on ch3
    drive_key(4'b0110, 4'b1001, 4'b0000, 4'b1001);
    drain();
    mode = 4'b1000;
    tick(3);
    check("follow_to_toggle_hold", led, 4'b1001);
    mode = 4'b0000;
    tick(3);
    check("toggle_to_follow_pressed", led, 4'b1001);
    drive_key(4'b1111, 4'b0000, 4'b1001, 4'b0000);
    drain();

    // reset while ch0 counter sits at 5
    key = 4'b1110;
    tick(7);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    sb.push_back('{cyc + 10, 4'b0001, 4'b0000, 4'b0001});
    tick(1);
    check("no_pulse_orig_accept", key_press, 0);
    check("led_after_reset", led, 0);
    drain();
    drive_key(4'b1111, 4'b0000, 4'b0001, 4'b0000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
